// File: rtl/dual_7seg_scan_driver.sv
// ---------------------------------------------------------------------------
// dual_7seg_scan_driver
//
// Converts a 9-bit binary count (normally 0..59) into two BCD digits with a
// repeated-subtraction converter, then time-multiplexes the two digits onto
// a shared 7-segment bus.
//
// Ports:
//   clk       - single clock, all state changes on its rising edge
//   rst       - asynchronous, active-high reset
//   value_in  - binary value to show; values >= 100 display as "--"
//   seg       - segment drive, seg[0]=a .. seg[6]=g (polarity per COMMON_ANODE)
//   dp        - decimal point, held inactive
//   an        - digit enables, an[0]=ones, an[1]=tens (polarity per COMMON_ANODE)
//   tens_bcd  - committed tens digit
//   ones_bcd  - committed ones digit
//   busy      - high while a conversion is in progress
// ---------------------------------------------------------------------------
module dual_7seg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int COMMON_ANODE = 0,
    parameter int BLANK_LZ     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] value_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] an,
    output logic [3:0] tens_bcd,
    output logic [3:0] ones_bcd,
    output logic       busy
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    // Active-low boards see every segment/enable bit inverted.
    localparam logic [6:0] SEG_POL = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_POL  = (COMMON_ANODE != 0) ? 2'b11 : 2'b00;
    localparam logic       DP_POL  = (COMMON_ANODE != 0) ? 1'b1  : 1'b0;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state_r;
    logic            first_pending_r;
    logic            valid_r;
    logic            ovf_r;       // committed overflow, drives the display
    logic            ovf_pend_r;  // overflow seen at capture, not yet committed
    logic [8:0]      last_value_r;
    logic [8:0]      rem_r;
    logic [3:0]      tens_acc_r;
    logic [CW-1:0]   cnt_r;
    logic            sel_r;
    logic [6:0]      seg_s;
    logic [1:0]      an_s;

    // Active-high gfedcba pattern for one decimal digit.
    function automatic logic [6:0] seg7_encode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    assign busy = (state_r == CONV);

    // Capture/convert/commit FSM; digits change only on the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            first_pending_r <= 1'b1;
            valid_r         <= 1'b0;
            ovf_r           <= 1'b0;
            ovf_pend_r      <= 1'b0;
            last_value_r    <= 9'd0;
            rem_r           <= 9'd0;
            tens_acc_r      <= 4'd0;
            tens_bcd        <= 4'd0;
            ones_bcd        <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if ((value_in != last_value_r) || first_pending_r) begin
                        rem_r           <= value_in;
                        last_value_r    <= value_in;
                        tens_acc_r      <= 4'd0;
                        first_pending_r <= 1'b0;
                        ovf_pend_r      <= (value_in >= 9'd100);
                        state_r         <= CONV;
                    end
                end
                CONV: begin
                    if (ovf_pend_r) begin
                        ovf_r    <= 1'b1;
                        tens_bcd <= 4'd0;
                        ones_bcd <= 4'd0;
                        valid_r  <= 1'b1;
                        state_r  <= IDLE;
                    end else if (rem_r >= 9'd10) begin
                        rem_r      <= rem_r - 9'd10;
                        tens_acc_r <= tens_acc_r + 4'd1;
                    end else begin
                        tens_bcd <= tens_acc_r;
                        ones_bcd <= rem_r[3:0];
                        ovf_r    <= 1'b0;
                        valid_r  <= 1'b1;
                        state_r  <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Scan timebase: sel flips each time the slot counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            sel_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            sel_r <= ~sel_r;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Active-high pattern for the slot currently selected.
    always_comb begin
        seg_s = SEG_BLANK;
        an_s  = 2'b00;
        if (!valid_r) begin
            seg_s = SEG_BLANK;
            an_s  = 2'b00;
        end else if (!sel_r) begin
            an_s  = 2'b01;
            seg_s = ovf_r ? SEG_DASH : seg7_encode(ones_bcd);
        end else begin
            an_s = 2'b10;
            if (ovf_r) begin
                seg_s = SEG_DASH;
            end else if ((BLANK_LZ != 0) && (tens_bcd == 4'd0)) begin
                seg_s = SEG_BLANK;
            end else begin
                seg_s = seg7_encode(tens_bcd);
            end
        end
    end

    // Registered pad drive with board polarity applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK ^ SEG_POL;
            an  <= AN_POL;
            dp  <= DP_POL;
        end else begin
            seg <= seg_s ^ SEG_POL;
            an  <= an_s ^ AN_POL;
            dp  <= DP_POL;
        end
    end

endmodule

// File: doc/dual_7seg_scan_driver.md
DUAL_7SEG_SCAN_DRIVER -- requirements
Module: dual_7seg_scan_driver

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, clk cycles each digit stays enabled per scan slot (legal range >= 2).
REQ-002 Parameter: COMMON_ANODE, default 0; 0 = seg and an active-high, 1 = seg and an active-low (bitwise inverted).
REQ-003 Parameter: BLANK_LZ, default 1; 1 = blank the tens digit when it is zero.
REQ-004 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: value_in  input  9  unsigned binary count from the upstream 0..59 counter; any 9-bit value is legal.
REQ-007 Port: seg  output  7  segment drive, seg[0]=a ... seg[6]=g, polarity per COMMON_ANODE.
REQ-008 Port: dp  output  1  decimal point, always inactive.
REQ-009 Port: an  output  2  digit enables, an[0]=ones, an[1]=tens, polarity per COMMON_ANODE.
REQ-010 Port: tens_bcd  output  4  committed tens digit (0..9).
REQ-011 Port: ones_bcd  output  4  committed ones digit (0..9).
REQ-012 Port: busy  output  1  high while a conversion is in progress.

Function
REQ-013 Converter FSM states: IDLE, CONV; busy=1 exactly when state=CONV.
REQ-014 In IDLE, if value_in != last_value or first_pending=1, the block shall capture value_in into rem and last_value, clear the tens accumulator and first_pending, and enter CONV on that edge.
REQ-015 Captured value >= 100 shall set ovf; at the next edge CONV shall commit ovf, with tens_bcd=0 and ones_bcd=0, and return to IDLE (latency 2 edges).
REQ-016 In CONV without ovf: each edge with rem >= 10 shall subtract 10 from rem and increment the tens accumulator; the edge with rem < 10 shall commit tens_bcd=tens accumulator, ones_bcd=rem, clear ovf, set valid=1, and return to IDLE.
REQ-017 Latency from the capture edge to the commit edge, inclusive, shall be (value div 10)+2 edges for values 0..99; for 59 this is 7 edges.
REQ-018 value_in changes while busy=1 shall be ignored; they are re-compared on the first IDLE cycle after the commit.
REQ-019 Committed digits shall be stable between commits; intermediate results shall never appear on seg, tens_bcd or ones_bcd.
REQ-020 Scan counter shall count 0..REFRESH_DIV-1 and wrap to 0; sel shall toggle on each wrap; sel=0 selects ones, sel=1 selects tens.
REQ-021 Active-high segment codes (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40, blank=00.
REQ-022 If ovf is committed, both digits shall display dash.
REQ-023 If BLANK_LZ=1, tens_bcd=0 and ovf=0, the tens slot shall display blank; its an bit is still asserted.
REQ-024 Before the first commit (valid=0), both an bits shall be inactive and seg shall be blank.
REQ-025 seg, an and dp shall be registered outputs; they reflect sel and the committed digits one edge after either changes.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, first_pending=1, valid=0, ovf=0, tens_bcd=0, ones_bcd=0, busy=0, scan counter=0, sel=0.
REQ-027 On rst=1, asynchronously: seg=blank, an=inactive, dp=inactive, each in the polarity set by COMMON_ANODE.
REQ-028 Reset asserted mid-conversion shall abort the conversion without committing.
REQ-029 After reset releases, the first IDLE edge shall capture value_in unconditionally, even if it equals last_value.

Verification
REQ-030 Reset release with value_in=0 -> capture edge, commit 2 edges after release, tens_bcd=0, ones_bcd=0; with BLANK_LZ=1, ones slot seg=3F and tens slot seg=00.
REQ-031 value_in 0->59 while IDLE -> busy high for 6 cycles; commit on the 7th edge after capture with tens_bcd=5, ones_bcd=9; tens slot seg=6D, ones slot seg=6F.
REQ-032 REFRESH_DIV=4 -> an alternates 01/10 every 4 cycles once valid=1; seg matches the digit selected in each slot.
REQ-033 value_in=150 -> commit 2 edges after capture; both slots seg=40; tens_bcd=0, ones_bcd=0.
REQ-034 value_in changes 59->0 during busy, then 0->7 -> 59 is committed first; the next capture is 7 and commits tens=0, ones=7, with no intermediate value displayed.
REQ-035 COMMON_ANODE=1, digit 8 -> seg=00 and active an bit=0; rst pulse mid-conversion -> an=11 and seg=7F immediately, with no commit.
